// File: rtl/wall_rom_arbiter_if.sv
// Renderer/ROM side bundle for the wall sprite ROM arbiter.
// slave: the arbiter; master: renderers plus the ROM q return.
interface wall_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 6
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ack;
    logic [ADDR_W-1:0]         rom_address;
    logic                      rom_clken;
    logic [DATA_W-1:0]         rom_readdata;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [2:0]                rsp_id;
    logic                      rsp_last;
    logic                      busy;

    modport slave (
        input  req, req_addr, req_len, rom_readdata,
        output req_ack, rom_address, rom_clken,
        output rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

    modport master (
        output req, req_addr, req_len, rom_readdata,
        input  req_ack, rom_address, rom_clken,
        input  rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );
endinterface

// File: rtl/wall_rom_arbiter.sv
// Round-robin burst arbiter for the shared 1024x8 wall sprite ROM.
// Optional WALL_ARB_PRIO0_EN: requester 0 always wins when requesting.
module wall_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 6
) (
    input  logic clk,
    input  logic reset_n,
    wall_rom_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    state_t             state_nx;
    logic [2:0]         ptr;
    logic [2:0]         ptr_nx;
    logic [2:0]         owner;
    logic [2:0]         win;
    logic [2:0]         pos;
    logic [7:0]         req_pad;
    logic               found;
    logic               grant;
    logic               last;
    logic               busy;
    logic [NUM_REQ-1:0] ack;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   remain;
    logic [LEN_W-1:0]   sel_len;
    logic               clken_q;
    logic               rsp_valid_q;
    logic               rsp_last_q;
    logic [2:0]         rsp_id_q;

    // Winner search: first set request at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        pos     = '0;
        req_pad = 8'(bus.req);
`ifdef WALL_ARB_PRIO0_EN
        if (req_pad[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = 3'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_pad[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    // Mux out the winner's base address and length (0 counts as 1).
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == 3'(k)) begin
                sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
                sel_len  = bus.req_len[k*LEN_W +: LEN_W];
            end
        end
        if (sel_len == '0) begin
            sel_len = LEN_W'(1);
        end
    end

    // Arbitration is held off until the ROM clock enable is up after reset.
    assign grant  = (state == IDLE) && clken_q && found;
    assign last   = (remain == LEN_W'(1));
    assign busy   = (state == BURST);
    assign ptr_nx = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and the one-cycle acknowledge pulse.
    always_comb begin
        state_nx = state;
        ack      = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        for (int k = 0; k < NUM_REQ; k++) begin
            ack[k] = grant && (win == 3'(k));
        end
    end

    // Burst address/length counters, owner and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr <= '0;
            remain   <= '0;
            owner    <= '0;
            ptr      <= '0;
        end else if (grant) begin
            cur_addr <= sel_addr;
            remain   <= sel_len;
            owner    <= win;
`ifdef WALL_ARB_PRIO0_EN
            if (win != 3'd0) begin
                ptr <= ptr_nx;
            end
`else
            ptr <= ptr_nx;
`endif
        end else if (busy) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            remain   <= remain - LEN_W'(1);
        end
    end

    // Response tags lag the address by the ROM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clken_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            clken_q     <= 1'b1;
            rsp_valid_q <= busy;
            rsp_last_q  <= busy && last;
            rsp_id_q    <= owner;
        end
    end

    assign bus.req_ack     = ack;
    assign bus.rom_address = busy ? cur_addr : '0;
    assign bus.rom_clken   = clken_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_valid_q ? bus.rom_readdata : '0;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_wall_rom_arbiter.sv
// Scoreboard bench for wall_rom_arbiter: grants, addresses and tagged bytes.
// A negedge monitor pops expected items pushed by the directed tests.
module tb_wall_rom_arbiter;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   ack_cyc [NR];
    int   first_cyc = 0;
    int   last_cyc = 0;
    logic prev_valid = 1'b0;

    int          qack [$];
    logic [AW-1:0] qaddr [$];
    logic [11:0] qrsp [$];

    always #5 clk = ~clk;

    wall_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    wall_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    function automatic logic [7:0] rom_byte(int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (bus.rom_clken) bus.rom_readdata <= rom_byte(int'(bus.rom_address));
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(string nm);
        total++;
        $display("FAIL %s: got timeout/underflow expected event", nm);
    endtask

    task automatic expect_burst(int id, int addr, int len);
        int n;
        int a;
        n = (len == 0) ? 1 : len;
        qack.push_back(id);
        for (int i = 0; i < n; i++) begin
            a = (addr + i) % 1024;
            qaddr.push_back(AW'(a));
            qrsp.push_back({3'(id), rom_byte(a), 1'(i == n - 1)});
        end
    endtask

    task automatic request(int id, int addr, int len);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.req_addr[id*AW +: AW] = AW'(addr);
        bus.req_len[id*LW +: LW] = LW'(len);
        bus.req[id] = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            if (bus.req_ack[id]) break;
            n++;
        end
        if (n >= 100) fail_now("ack_wait");
        @(posedge clk);
        #1 bus.req[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qack.size() + qaddr.size() + qrsp.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain");
        repeat (2) @(posedge clk);
    endtask

    task automatic check_idle_outputs(string nm);
        chk({nm, "_ack"}, 32'(bus.req_ack), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_addr"}, 32'(bus.rom_address), 0);
        chk({nm, "_clken"}, 32'(bus.rom_clken), 0);
        chk({nm, "_valid"}, 32'(bus.rsp_valid), 0);
        chk({nm, "_data"}, 32'(bus.rsp_data), 0);
        chk({nm, "_id"}, 32'(bus.rsp_id), 0);
        chk({nm, "_last"}, 32'(bus.rsp_last), 0);
    endtask

    // Monitor: compare every grant, issued address and returned byte.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < NR; k++) begin
                if (bus.req_ack[k]) begin
                    ack_cyc[k] = cyc;
                    if (qack.size() == 0) fail_now("unexpected_ack");
                    else chk("grant_id", k, qack.pop_front());
                end
            end
            if (bus.busy) begin
                if (qaddr.size() == 0) fail_now("unexpected_addr");
                else chk("rom_address", 32'(bus.rom_address), 32'(qaddr.pop_front()));
            end
            if (bus.rsp_valid) begin
                if (!prev_valid) first_cyc = cyc;
                if (bus.rsp_last) last_cyc = cyc;
                if (qrsp.size() == 0) fail_now("unexpected_rsp");
                else chk("rsp_id_data_last", 32'({bus.rsp_id, bus.rsp_data, bus.rsp_last}),
                         32'(qrsp.pop_front()));
            end else begin
                chk("rsp_data_gated", 32'(bus.rsp_data), 0);
                chk("rsp_last_gated", 32'(bus.rsp_last), 0);
            end
            prev_valid = bus.rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        int acks;
        int guard;
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_len = '0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 chk("clken_after_reset", 32'(bus.rom_clken), 1);

        // Contention from pointer 0: grants 0,2,3 with one idle cycle each.
        expect_burst(0, 'h080, 2);
        expect_burst(2, 'h0a0, 2);
        expect_burst(3, 'h0c0, 2);
        fork
            request(0, 'h080, 2);
            request(2, 'h0a0, 2);
            request(3, 'h0c0, 2);
        join
        drain();
        chk("gap_0_to_2", ack_cyc[2] - ack_cyc[0], 3);
        chk("gap_2_to_3", ack_cyc[3] - ack_cyc[2], 3);

        // Single burst latency.
        expect_burst(1, 'h040, 4);
        request(1, 'h040, 4);
        drain();
        chk("single_first_valid", first_cyc - ack_cyc[1], 2);
        chk("single_last", last_cyc - ack_cyc[1], 5);

        // Address wrap 1022,1023,0,1.
        expect_burst(3, 1022, 4);
        request(3, 1022, 4);
        drain();
        chk("wrap_last", last_cyc - ack_cyc[3], 5);

        // Zero length issues exactly one address.
        expect_burst(0, 'h100, 0);
        request(0, 'h100, 0);
        drain();
        chk("zero_len_first_is_last", first_cyc, last_cyc);
        chk("zero_len_latency", last_cyc - ack_cyc[0], 2);

        // Reset during the third address of a len=8 burst.
        qack.push_back(2);
        qaddr.push_back(AW'('h200));
        qaddr.push_back(AW'('h201));
        qrsp.push_back({3'd2, rom_byte('h200), 1'b0});
        request(2, 'h200, 8);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("midreset");
        chk("midreset_queues_used", qack.size() + qaddr.size() + qrsp.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 chk("clken_after_midreset", 32'(bus.rom_clken), 1);

        // Pointer restarted at 0: 2 wins before 3.
        expect_burst(2, 'h010, 1);
        expect_burst(3, 'h020, 2);
        fork
            request(2, 'h010, 1);
            request(3, 'h020, 2);
        join
        drain();

        // Requesters 0 and 1 held continuously for four grants.
`ifdef WALL_ARB_PRIO0_EN
        expect_burst(0, 'h300, 1);
        expect_burst(0, 'h300, 1);
        expect_burst(0, 'h300, 1);
        expect_burst(0, 'h300, 1);
`else
        expect_burst(0, 'h300, 1);
        expect_burst(1, 'h310, 1);
        expect_burst(0, 'h300, 1);
        expect_burst(1, 'h310, 1);
`endif
        @(posedge clk);
        #1;
        bus.req_addr[0*AW +: AW] = AW'('h300);
        bus.req_len[0*LW +: LW] = LW'(1);
        bus.req_addr[1*AW +: AW] = AW'('h310);
        bus.req_len[1*LW +: LW] = LW'(1);
        bus.req[1:0] = 2'b11;
        acks = 0;
        guard = 0;
        while (acks < 4 && guard < 200) begin
            @(negedge clk);
            if (bus.req_ack != '0) acks++;
            guard++;
        end
        if (acks < 4) fail_now("held_req_acks");
        @(posedge clk);
        #1 bus.req[1:0] = 2'b00;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
